// File: rtl/detector_colisao_pkg.sv
// detector_colisao_pkg: raster, sprite and score constants plus FSM encoding shared with the video core
package detector_colisao_pkg;

    localparam int N_ALIENS = 8;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 525;
    localparam int PONTOS   = 10;
    localparam int PONT_MAX = 999;
    localparam int PONT_W   = 12;

    typedef enum logic {JOGANDO, FIM} estado_t;

    // One alien's worth of points, clamped to what three decimal digits can show
    function automatic logic [PONT_W-1:0] soma_sat(input logic [PONT_W-1:0] a);
        logic [PONT_W:0] s;
        s = {1'b0, a} + (PONT_W+1)'(PONTOS);
        return (s > (PONT_W+1)'(PONT_MAX)) ? PONT_W'(PONT_MAX) : s[PONT_W-1:0];
    endfunction

endpackage

// File: rtl/detector_colisao_prio_onehot.sv
// prio_onehot: keeps only the lowest set bit of the request vector
module prio_onehot #(
    parameter int W = 8
) (
    input  logic [W-1:0] req,
    output logic [W-1:0] onehot
);

    assign onehot = req & (-req);

endmodule

// File: rtl/detector_colisao.sv
// detector_colisao: per-frame collision accumulation, alien kill/score commit and game-over FSM
module detector_colisao
    import detector_colisao_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                pix_en,
    input  logic [9:0]          h_counter,
    input  logic [9:0]          v_counter,
    input  logic                tiro_pix,
    input  logic                bomba_pix,
    input  logic                nave_pix,
    input  logic [N_ALIENS-1:0] alien_pix,
    input  logic                reiniciar,
    output logic                acerto,
    output logic [N_ALIENS-1:0] alien_atingido,
    output logic [N_ALIENS-1:0] vivos,
    output logic [PONT_W-1:0]   pontuacao,
    output logic [PONT_W-1:0]   record,
    output logic                fim_jogo
);

    estado_t             estado;
    logic [N_ALIENS-1:0] hit_acc;
    logic [N_ALIENS-1:0] sel;
    logic [N_ALIENS-1:0] vivos_kill;
    logic [N_ALIENS-1:0] vivos_next;
    logic [PONT_W-1:0]   pont_next;
    logic                nave_acc;
    logic                amostra;
    logic                fim_quadro;

    assign amostra    = pix_en && (h_counter < 10'(H_ACTIVE)) && (v_counter < 10'(V_ACTIVE));
    assign fim_quadro = pix_en && (h_counter == 10'(H_TOTAL-1)) && (v_counter == 10'(V_TOTAL-1));

    prio_onehot #(.W(N_ALIENS)) u_prio (
        .req    (hit_acc),
        .onehot (sel)
    );

    // Next alive mask and score for a commit; an emptied wave reloads immediately
    always_comb begin
        vivos_kill = vivos & ~sel;
        vivos_next = (vivos_kill == '0) ? '1 : vivos_kill;
        pont_next  = (hit_acc != '0) ? soma_sat(pontuacao) : pontuacao;
    end

    // Overlap accumulators: OR over the visible area during play, cleared at every frame end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_acc  <= '0;
            nave_acc <= 1'b0;
        end else if (fim_quadro) begin
            hit_acc  <= '0;
            nave_acc <= 1'b0;
        end else if (amostra && estado == JOGANDO) begin
            hit_acc  <= hit_acc | (alien_pix & vivos & {N_ALIENS{tiro_pix}});
            nave_acc <= nave_acc | (bomba_pix & nave_pix);
        end
    end

    // Game FSM with registered outputs; the hit is scored before the game-over record compare
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado         <= JOGANDO;
            vivos          <= '1;
            acerto         <= 1'b0;
            alien_atingido <= '0;
            pontuacao      <= '0;
            record         <= '0;
            fim_jogo       <= 1'b0;
        end else begin
            acerto         <= 1'b0;
            alien_atingido <= '0;
            if (estado == FIM) begin
                if (reiniciar) begin
                    estado    <= JOGANDO;
                    fim_jogo  <= 1'b0;
                    pontuacao <= '0;
                    vivos     <= '1;
                end
            end else if (fim_quadro) begin
                if (hit_acc != '0) begin
                    acerto         <= 1'b1;
                    alien_atingido <= sel;
                    vivos          <= vivos_next;
                    pontuacao      <= pont_next;
                end
                if (nave_acc) begin
                    estado   <= FIM;
                    fim_jogo <= 1'b1;
                    record   <= (pont_next > record) ? pont_next : record;
                end
            end
        end
    end

endmodule

// File: tb/tb_detector_colisao.sv
// tb_detector_colisao: directed frame vectors plus wave-wrap, saturation, restart and reset sequences
module tb_detector_colisao;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pix_en = 1'b0;
    logic [9:0]  h_counter = '0;
    logic [9:0]  v_counter = '0;
    logic        tiro_pix = 1'b0;
    logic        bomba_pix = 1'b0;
    logic        nave_pix = 1'b0;
    logic [7:0]  alien_pix = '0;
    logic        reiniciar = 1'b0;
    logic        acerto;
    logic [7:0]  alien_atingido;
    logic [7:0]  vivos;
    logic [11:0] pontuacao;
    logic [11:0] record;
    logic        fim_jogo;

    int checks = 0;
    int errors = 0;

    detector_colisao dut (
        .clk            (clk),
        .reset          (reset),
        .pix_en         (pix_en),
        .h_counter      (h_counter),
        .v_counter      (v_counter),
        .tiro_pix       (tiro_pix),
        .bomba_pix      (bomba_pix),
        .nave_pix       (nave_pix),
        .alien_pix      (alien_pix),
        .reiniciar      (reiniciar),
        .acerto         (acerto),
        .alien_atingido (alien_atingido),
        .vivos          (vivos),
        .pontuacao      (pontuacao),
        .record         (record),
        .fim_jogo       (fim_jogo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rein;
        logic        pe;
        logic [9:0]  h;
        logic [9:0]  v;
        logic        tiro;
        logic        bomba;
        logic        nave;
        logic [7:0]  alien;
        int          npix;
        logic        e_acerto;
        logic [7:0]  e_hit;
        logic [7:0]  e_vivos;
        logic [11:0] e_pont;
        logic [11:0] e_rec;
        logic        e_fim;
    } vec_t;

    vec_t tab [15];

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nome, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic a, input logic [7:0] hit, input logic [7:0] viv,
                           input logic [11:0] p, input logic [11:0] r, input logic f);
        chk({tag, ".acerto"}, 32'(acerto), 32'(a));
        chk({tag, ".alien_atingido"}, 32'(alien_atingido), 32'(hit));
        chk({tag, ".vivos"}, 32'(vivos), 32'(viv));
        chk({tag, ".pontuacao"}, 32'(pontuacao), 32'(p));
        chk({tag, ".record"}, 32'(record), 32'(r));
        chk({tag, ".fim_jogo"}, 32'(fim_jogo), 32'(f));
    endtask

    task automatic pix(input logic pe, input logic [9:0] h, input logic [9:0] v, input logic t,
                       input logic b, input logic n, input logic [7:0] a, input logic r);
        pix_en = pe; h_counter = h; v_counter = v;
        tiro_pix = t; bomba_pix = b; nave_pix = n; alien_pix = a; reiniciar = r;
        @(posedge clk); #1;
        pix_en = 1'b0; tiro_pix = 1'b0; bomba_pix = 1'b0; nave_pix = 1'b0; alien_pix = '0; reiniciar = 1'b0;
    endtask

    task automatic fe(input logic r);
        pix_en = 1'b1; h_counter = 10'd799; v_counter = 10'd524; reiniciar = r;
        @(posedge clk); #1;
        pix_en = 1'b0; reiniciar = 1'b0; h_counter = '0; v_counter = '0;
    endtask

    task automatic idle_pulse_check(input string tag);
        @(posedge clk); #1;
        chk({tag, ".acerto_fall"}, 32'(acerto), 32'd0);
        chk({tag, ".hit_fall"}, 32'(alien_atingido), 32'd0);
    endtask

    initial begin
        logic [11:0] ep;
        logic [7:0]  ev;
        string       tag;

        tab[0]  = '{0, 1, 10,  10,  1, 0, 0, 8'h08, 4, 1, 8'h08, 8'hF7, 12'd10, 12'd0,  0};
        tab[1]  = '{0, 1, 10,  10,  1, 0, 0, 8'h24, 1, 1, 8'h04, 8'hF3, 12'd20, 12'd0,  0};
        tab[2]  = '{0, 1, 10,  10,  1, 0, 0, 8'h24, 1, 1, 8'h20, 8'hD3, 12'd30, 12'd0,  0};
        tab[3]  = '{0, 1, 20,  30,  0, 1, 1, 8'h00, 1, 0, 8'h00, 8'hD3, 12'd30, 12'd30, 1};
        tab[4]  = '{0, 1, 10,  10,  1, 0, 0, 8'h01, 2, 0, 8'h00, 8'hD3, 12'd30, 12'd30, 1};
        tab[5]  = '{1, 1, 10,  10,  0, 0, 0, 8'h00, 1, 0, 8'h00, 8'hFF, 12'd0,  12'd30, 0};
        tab[6]  = '{0, 1, 640, 10,  1, 0, 0, 8'h01, 1, 0, 8'h00, 8'hFF, 12'd0,  12'd30, 0};
        tab[7]  = '{0, 1, 10,  480, 1, 0, 0, 8'h01, 1, 0, 8'h00, 8'hFF, 12'd0,  12'd30, 0};
        tab[8]  = '{0, 0, 10,  10,  1, 0, 0, 8'h01, 1, 0, 8'h00, 8'hFF, 12'd0,  12'd30, 0};
        tab[9]  = '{0, 1, 639, 479, 1, 0, 0, 8'h01, 1, 1, 8'h01, 8'hFE, 12'd10, 12'd30, 0};
        tab[10] = '{0, 1, 10,  10,  1, 0, 0, 8'h02, 1, 1, 8'h02, 8'hFC, 12'd20, 12'd30, 0};
        tab[11] = '{0, 1, 10,  10,  1, 0, 0, 8'h04, 1, 1, 8'h04, 8'hF8, 12'd30, 12'd30, 0};
        tab[12] = '{0, 1, 10,  10,  1, 1, 1, 8'h08, 1, 1, 8'h08, 8'hF0, 12'd40, 12'd40, 1};
        tab[13] = '{1, 1, 10,  10,  0, 0, 0, 8'h00, 1, 0, 8'h00, 8'hFF, 12'd0,  12'd40, 0};
        tab[14] = '{0, 1, 10,  10,  0, 1, 0, 8'h00, 1, 0, 8'h00, 8'hFF, 12'd0,  12'd40, 0};

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset_held", 0, 8'h00, 8'hFF, 12'd0, 12'd0, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk_all("reset_rel", 0, 8'h00, 8'hFF, 12'd0, 12'd0, 0);

        for (int i = 0; i < 15; i++) begin
            for (int p = 0; p < tab[i].npix; p++)
                pix(tab[i].pe, tab[i].h, tab[i].v, tab[i].tiro, tab[i].bomba, tab[i].nave, tab[i].alien, tab[i].rein);
            fe(1'b0);
            tag = $sformatf("vec%0d", i);
            chk_all(tag, tab[i].e_acerto, tab[i].e_hit, tab[i].e_vivos, tab[i].e_pont, tab[i].e_rec, tab[i].e_fim);
            idle_pulse_check(tag);
        end

        for (int k = 0; k < 8; k++) begin
            pix(1'b1, 10'd100, 10'd100, 1'b1, 1'b0, 1'b0, 8'(1 << k), 1'b0);
            fe(1'b0);
            ev = 8'hFF;
            ev = (k == 7) ? 8'hFF : 8'(ev << (k + 1));
            tag = $sformatf("wave%0d", k);
            chk_all(tag, 1, 8'(1 << k), ev, 12'(10 * (k + 1)), 12'd40, 0);
        end

        ep = 12'd80;
        for (int f = 0; f < 200 && ep < 12'd990; f++) begin
            pix(1'b1, 10'd50, 10'd60, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0);
            fe(1'b0);
            ep = ep + 12'd10;
            chk("climb.acerto", 32'(acerto), 32'd1);
            chk("climb.pontuacao", 32'(pontuacao), 32'(ep));
        end
        for (int f = 0; f < 2; f++) begin
            pix(1'b1, 10'd50, 10'd60, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0);
            fe(1'b0);
            chk("sat.acerto", 32'(acerto), 32'd1);
            chk("sat.pontuacao", 32'(pontuacao), 32'd999);
        end

        pix(1'b1, 10'd50, 10'd60, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0);
        fe(1'b0);
        chk("over.acerto", 32'(acerto), 32'd1);
        chk("over.pontuacao", 32'(pontuacao), 32'd999);
        chk("over.record", 32'(record), 32'd999);
        chk("over.fim_jogo", 32'(fim_jogo), 32'd1);
        ev = vivos;

        pix(1'b1, 10'd50, 10'd60, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0);
        fe(1'b0);
        chk_all("fim_quiet", 0, 8'h00, ev, 12'd999, 12'd999, 1);

        pix(1'b1, 10'd50, 10'd60, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0);
        fe(1'b1);
        chk_all("rein_commit", 0, 8'h00, 8'hFF, 12'd0, 12'd999, 0);
        idle_pulse_check("rein_commit");

        pix(1'b1, 10'd50, 10'd60, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk_all("async_reset", 0, 8'h00, 8'hFF, 12'd0, 12'd0, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        pix(1'b1, 10'd50, 10'd60, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        fe(1'b0);
        chk_all("post_reset_commit", 0, 8'h00, 8'hFF, 12'd0, 12'd0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
